// File: rtl/diviseur_pkg.sv
// rtl/diviseur_pkg.sv - shared constants and helpers for the multi-channel divider
package diviseur_pkg;

    localparam int CH_SEL_W = 3;

    // Default settings of the telemeter channels: burst carrier and measurement gate
    localparam int DIV_CARRIER = 49;
    localparam int PR_CARRIER  = 25;
    localparam int DIV_GATE    = 999;
    localparam int PR_GATE     = 500;

    function automatic logic frq_level(input logic active, input logic polarity);
        return active ? polarity : ~polarity;
    endfunction

endpackage

// File: rtl/diviseur_canal.sv
// rtl/diviseur_canal.sv - one divider/PWM channel with shadowed period and high-time
module diviseur_canal
    import diviseur_pkg::*;
#(
    parameter int   REG_SIZE = 16,
    parameter logic POLARITY = 1'b1,
    parameter int   DIV_RST  = 49,
    parameter int   PR_RST   = 25
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                ena,
    input  logic                wr,
    input  logic [REG_SIZE-1:0] div_in,
    input  logic [REG_SIZE-1:0] pr_in,
    output logic                pend,
    output logic                tick,
    output logic                frq
);

    logic [REG_SIZE-1:0] cnt;
    logic [REG_SIZE-1:0] div_act;
    logic [REG_SIZE-1:0] pr_act;
    logic [REG_SIZE-1:0] div_pend;
    logic [REG_SIZE-1:0] pr_pend;
    logic                wrap;

    assign wrap = (cnt == div_act);

    always_ff @(negedge Clk) begin
        if (Rst) begin
            cnt      <= '0;
            div_act  <= REG_SIZE'(DIV_RST);
            pr_act   <= REG_SIZE'(PR_RST);
            div_pend <= '0;
            pr_pend  <= '0;
            pend     <= 1'b0;
            tick     <= 1'b0;
            frq      <= ~POLARITY;
        end else begin
            if (ena) begin
                cnt  <= wrap ? '0 : cnt + 1'b1;
                frq  <= frq_level(cnt < pr_act, POLARITY);
                tick <= wrap;
            end else begin
                cnt  <= '0;
                frq  <= ~POLARITY;
                tick <= 1'b0;
            end

            // A write on the wrap edge only shadows; the wrap itself keeps the old settings
            if (wr) begin
                div_pend <= div_in;
                pr_pend  <= pr_in;
                pend     <= 1'b1;
            end else if (pend && (!ena || wrap)) begin
                div_act <= div_pend;
                pr_act  <= pr_pend;
                pend    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/diviseur_frequence_multi.sv
// rtl/diviseur_frequence_multi.sv - NB_CH independent programmable dividers with one write port
module diviseur_frequence_multi
    import diviseur_pkg::*;
#(
    parameter int   NB_CH    = 2,
    parameter int   REG_SIZE = 16,
    parameter logic POLARITY = 1'b1,
    parameter int   DIV_RST  = 49,
    parameter int   PR_RST   = 25
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [NB_CH-1:0]    Ena,
    input  logic                Wr,
    input  logic [CH_SEL_W-1:0] Ch_sel,
    input  logic [REG_SIZE-1:0] Div_in,
    input  logic [REG_SIZE-1:0] Pr_in,
    output logic [NB_CH-1:0]    Pend,
    output logic [NB_CH-1:0]    Tick,
    output logic [NB_CH-1:0]    Frq
);

    logic [NB_CH-1:0] wr_ch;

    // Ch_sel values with no matching channel decode to no strobe at all
    for (genvar i = 0; i < NB_CH; i++) begin : g_canal
        assign wr_ch[i] = Wr && (Ch_sel == CH_SEL_W'(i));

        diviseur_canal #(
            .REG_SIZE (REG_SIZE),
            .POLARITY (POLARITY),
            .DIV_RST  (DIV_RST),
            .PR_RST   (PR_RST)
        ) u_canal (
            .Clk    (Clk),
            .Rst    (Rst),
            .ena    (Ena[i]),
            .wr     (wr_ch[i]),
            .div_in (Div_in),
            .pr_in  (Pr_in),
            .pend   (Pend[i]),
            .tick   (Tick[i]),
            .frq    (Frq[i])
        );
    end

endmodule

// File: tb/tb_diviseur_frequence_multi.sv
// tb/tb_diviseur_frequence_multi.sv - self-checking bench for diviseur_frequence_multi
module tb_diviseur_frequence_multi;

    localparam int NB = 2;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [NB-1:0] Ena;
    logic          Wr;
    logic [2:0]    Ch_sel;
    logic [15:0]   Div_in;
    logic [15:0]   Pr_in;
    logic [NB-1:0] Pend;
    logic [NB-1:0] Tick;
    logic [NB-1:0] Frq;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: position within the current period plus active/shadow settings
    int m_pos [NB];
    int m_div [NB];
    int m_pr  [NB];
    int m_pdiv[NB];
    int m_ppr [NB];
    bit m_pend[NB];
    bit m_tick[NB];
    bit m_frq [NB];

    diviseur_frequence_multi #(
        .NB_CH(NB), .REG_SIZE(16), .POLARITY(1'b1), .DIV_RST(49), .PR_RST(25)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Ena(Ena), .Wr(Wr), .Ch_sel(Ch_sel),
        .Div_in(Div_in), .Pr_in(Pr_in), .Pend(Pend), .Tick(Tick), .Frq(Frq)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3*NB-1:0] model_vec();
        logic [3*NB-1:0] v;
        for (int c = 0; c < NB; c++) begin
            v[2*NB+c] = m_pend[c];
            v[NB+c]   = m_tick[c];
            v[c]      = m_frq[c];
        end
        return v;
    endfunction

    task automatic model_edge();
        for (int c = 0; c < NB; c++) begin
            bit last;
            bit wr_c;
            last = (m_pos[c] == m_div[c]);
            wr_c = Wr && (int'(Ch_sel) == c);
            if (Rst) begin
                m_pos[c] = 0; m_div[c] = 49; m_pr[c] = 25; m_pdiv[c] = 0; m_ppr[c] = 0;
                m_pend[c] = 0; m_tick[c] = 0; m_frq[c] = 0;
            end else begin
                if (Ena[c]) begin
                    m_frq[c]  = (m_pos[c] < m_pr[c]);
                    m_tick[c] = last;
                    m_pos[c]  = (m_pos[c] + 1) % (m_div[c] + 1);
                end else begin
                    m_pos[c] = 0; m_frq[c] = 0; m_tick[c] = 0;
                end
                if (wr_c) begin
                    m_pdiv[c] = int'(Div_in); m_ppr[c] = int'(Pr_in); m_pend[c] = 1;
                end else if (m_pend[c] && (!Ena[c] || last)) begin
                    m_div[c] = m_pdiv[c]; m_pr[c] = m_ppr[c]; m_pend[c] = 0;
                end
            end
        end
    endtask

    // Advance one active (falling) edge; outputs are stable 1 time unit later
    task automatic cycle();
        @(negedge Clk);
        model_edge();
        #1;
    endtask

    task automatic do_write(input int ch, input int d, input int p);
        Wr = 1'b1; Ch_sel = 3'(ch); Div_in = 16'(d); Pr_in = 16'(p);
        cycle();
        Wr = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Ena = '0; Wr = 1'b0; Ch_sel = '0; Div_in = '0; Pr_in = '0;
        cycle(); cycle();
        n_total++; if (Pend !== 2'b00) $display("FAIL reset_pend got=%b exp=00", Pend); else n_pass++;
        n_total++; if (Tick !== 2'b00) $display("FAIL reset_tick got=%b exp=00", Tick); else n_pass++;
        n_total++; if (Frq !== 2'b00)  $display("FAIL reset_frq got=%b exp=00", Frq);  else n_pass++;
        Rst = 1'b0;
    endtask

    task automatic test_defaults();
        int hi0 = 0, tk0 = 0, hi1 = 0, tk1 = 0;
        Ena = 2'b01;
        for (int i = 0; i < 100; i++) begin
            cycle();
            hi0 += int'(Frq[0]); tk0 += int'(Tick[0]); hi1 += int'(Frq[1]); tk1 += int'(Tick[1]);
            n_total++;
            if ({Pend, Tick, Frq} !== model_vec())
                $display("FAIL defaults_cycle%0d got=%b exp=%b", i, {Pend, Tick, Frq}, model_vec());
            else n_pass++;
        end
        n_total++; if (hi0 != 50) $display("FAIL defaults_ch0_high got=%0d exp=50", hi0); else n_pass++;
        n_total++; if (tk0 != 2)  $display("FAIL defaults_ch0_ticks got=%0d exp=2", tk0); else n_pass++;
        n_total++; if (hi1 != 0 || tk1 != 0) $display("FAIL defaults_ch1_idle got=%0d/%0d exp=0/0", hi1, tk1); else n_pass++;
    endtask

    // Wait (bounded) for Pend[ch] to fall, returning the number of edges taken
    task automatic wait_apply(input int ch, input int bound, output int n);
        n = 0;
        while (Pend[ch] === 1'b1 && n < bound) begin
            cycle(); n++;
        end
        n_total++;
        if (Pend[ch] !== 1'b0) $display("FAIL apply_timeout ch%0d got=%b exp=0", ch, Pend[ch]); else n_pass++;
    endtask

    task automatic measure(input int ch, input int len, output int hi, output int tk);
        hi = 0; tk = 0;
        for (int i = 0; i < len; i++) begin
            cycle();
            hi += int'(Frq[ch]); tk += int'(Tick[ch]);
        end
    endtask

    task automatic test_reprogram();
        int n, hi, tk;
        for (int i = 0; i < 17; i++) cycle();
        do_write(0, 9, 3);
        n_total++; if (Pend[0] !== 1'b1) $display("FAIL reprog_pend got=%b exp=1", Pend[0]); else n_pass++;
        wait_apply(0, 60, n);
        n_total++; if (Tick[0] !== 1'b1) $display("FAIL reprog_wrap_tick got=%b exp=1", Tick[0]); else n_pass++;
        measure(0, 10, hi, tk);
        n_total++; if (hi != 3 || tk != 1) $display("FAIL reprog_period got=%0d/%0d exp=3/1", hi, tk); else n_pass++;
    endtask

    task automatic test_edges();
        int hi, tk;
        do_write(1, 0, 0);
        cycle();
        Ena = 2'b11;
        cycle();
        measure(1, 10, hi, tk);
        n_total++; if (tk != 10) $display("FAIL edge_div0_tick got=%0d exp=10", tk); else n_pass++;
        n_total++; if (hi != 0)  $display("FAIL edge_pr0_frq got=%0d exp=0", hi); else n_pass++;
        do_write(1, 9, 20);
        cycle(); cycle();
        measure(1, 20, hi, tk);
        n_total++; if (hi != 20 || tk != 2) $display("FAIL edge_pr_gt_div got=%0d/%0d exp=20/2", hi, tk); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n, hi, tk;
        do_write(0, 4, 2);
        do_write(0, 7, 5);
        wait_apply(0, 20, n);
        measure(0, 8, hi, tk);
        n_total++; if (hi != 5 || tk != 1) $display("FAIL b2b_period got=%0d/%0d exp=5/1", hi, tk); else n_pass++;
        measure(0, 8, hi, tk);
        n_total++; if (hi != 5 || tk != 1) $display("FAIL b2b_period2 got=%0d/%0d exp=5/1", hi, tk); else n_pass++;
    endtask

    task automatic test_write_on_wrap();
        int n = 0, hi, tk;
        while (m_pos[0] != m_div[0] && n < 20) begin cycle(); n++; end
        do_write(0, 3, 1);
        n_total++; if (Pend[0] !== 1'b1 || Tick[0] !== 1'b1)
            $display("FAIL wrapwr_pend_tick got=%b%b exp=11", Pend[0], Tick[0]); else n_pass++;
        wait_apply(0, 20, n);
        n_total++; if (n != 8) $display("FAIL wrapwr_old_period got=%0d exp=8", n); else n_pass++;
        measure(0, 4, hi, tk);
        n_total++; if (hi != 1 || tk != 1) $display("FAIL wrapwr_new_period got=%0d/%0d exp=1/1", hi, tk); else n_pass++;
    endtask

    task automatic test_misc();
        int hi, tk;
        do_write(5, 2, 1);
        n_total++; if (Pend !== 2'b00) $display("FAIL badsel_pend got=%b exp=00", Pend); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            cycle();
            n_total++;
            if ({Pend, Tick, Frq} !== model_vec())
                $display("FAIL badsel_cycle%0d got=%b exp=%b", i, {Pend, Tick, Frq}, model_vec());
            else n_pass++;
        end
        Ena = 2'b01;
        do_write(1, 5, 2);
        n_total++; if (Pend[1] !== 1'b1) $display("FAIL dis_pend_set got=%b exp=1", Pend[1]); else n_pass++;
        cycle();
        n_total++; if (Pend[1] !== 1'b0) $display("FAIL dis_pend_clr got=%b exp=0", Pend[1]); else n_pass++;
        Ena = 2'b11;
        measure(1, 6, hi, tk);
        n_total++; if (hi != 2 || tk != 1) $display("FAIL dis_applied got=%0d/%0d exp=2/1", hi, tk); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int hi, tk;
        do_write(0, 30, 10);
        cycle();
        Rst = 1'b1;
        cycle();
        n_total++; if ({Pend, Tick, Frq} !== 6'b0)
            $display("FAIL rstmid_outputs got=%b exp=000000", {Pend, Tick, Frq}); else n_pass++;
        Rst = 1'b0; Ena = 2'b01;
        measure(0, 100, hi, tk);
        n_total++; if (hi != 50 || tk != 2) $display("FAIL rstmid_default got=%0d/%0d exp=50/2", hi, tk); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            Rst    = ($urandom_range(0, 199) == 0);
            Wr     = ($urandom_range(0, 5) == 0);
            Ch_sel = 3'($urandom_range(0, 7));
            Div_in = 16'($urandom_range(0, 20));
            Pr_in  = 16'($urandom_range(0, 24));
            if ($urandom_range(0, 29) == 0) Ena = NB'($urandom_range(0, 3));
            cycle();
            n_total++;
            if ({Pend, Tick, Frq} !== model_vec())
                $display("FAIL random_cycle%0d got=%b exp=%b", i, {Pend, Tick, Frq}, model_vec());
            else n_pass++;
        end
        Wr = 1'b0; Rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_reprogram();
        test_edges();
        test_back_to_back();
        test_write_on_wrap();
        test_misc();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
